button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 28 ++
 rtl/button_channel.sv | 187 ++++++++++++++++++
 rtl/button_conditioner.sv | 56 +++++
 tb/tb_button_conditioner.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner: the per-channel state
// encoding and the default timing constants used by button_channel and
// button_conditioner.
// -----------------------------------------------------------------------------
package button_pkg;

   localparam int unsigned STATE_W = 3;

   // Per-channel conditioner state. Values are fixed so that the state can be
   // read directly off the debug bus.
   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      PRESSED  = 3'd2,
      HELD     = 3'd3,
      REL_DB   = 3'd4
   } btn_state_e;

   // Default timing, in clock cycles.
   localparam int unsigned DEF_N_CH            = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int unsigned DEF_HOLD_TIME       = 100000000;
   localparam bit          DEF_REPEAT_EN       = 1'b0;
   localparam int unsigned DEF_REPEAT_TIME     = 25000000;

endpackage : button_pkg

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button channel: 2-flop synchronizer, debounce/hold FSM and counters.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_btn_raw    asynchronous raw level, 1 = pressed
//   o_level      debounced level
//   o_press      one-cycle pulse on debounced rise
//   o_release    one-cycle pulse on debounced fall
//   o_hold_pulse one-cycle long-press / auto-repeat pulse
//   o_hold_level high from the first hold pulse until debounced release
//   o_state      current FSM state (debug)
// -----------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_TIME       = DEF_HOLD_TIME,
   parameter bit          REPEAT_EN       = DEF_REPEAT_EN,
   parameter int unsigned REPEAT_TIME     = DEF_REPEAT_TIME
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_btn_raw,
   output logic               o_level,
   output logic               o_press,
   output logic               o_release,
   output logic               o_hold_pulse,
   output logic               o_hold_level,
   output logic [STATE_W-1:0] o_state
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_TIME + 1);
   localparam int unsigned REP_W  = $clog2(REPEAT_TIME + 1);

   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TIME);
   localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_TIME);

   logic              r_sync1, r_sync2;
   btn_state_e        r_state, w_state_nxt;
   btn_state_e        r_ret_state, w_ret_nxt;   // where REL_DB goes back to
   logic [DB_W-1:0]   r_db_cnt, w_db_nxt, w_db_inc;
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt, w_hold_inc;
   logic [REP_W-1:0]  r_rep_cnt, w_rep_nxt, w_rep_inc;
   logic              w_hold_sat, w_hold_hit;
   logic              r_level, w_level_nxt;
   logic              r_press, w_press_nxt;
   logic              r_release, w_release_nxt;
   logic              r_hold_pulse, w_hold_pulse_nxt;
   logic              r_hold_level, w_hold_level_nxt;

   // The debounce counter holds the length of the current run of samples
   // that disagree with the debounced level. It is zero in every state where
   // no run is in progress, so the increment also covers the entry sample.
   assign w_db_inc   = r_db_cnt + DB_W'(1);
   assign w_hold_sat = (r_hold_cnt == HOLD_MAX);
   assign w_hold_inc = w_hold_sat ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
   assign w_hold_hit = !w_hold_sat && (w_hold_inc == HOLD_MAX);
   assign w_rep_inc  = r_rep_cnt + REP_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1      <= 1'b0;
         r_sync2      <= 1'b0;
         r_state      <= IDLE;
         r_ret_state  <= IDLE;
         r_db_cnt     <= '0;
         r_hold_cnt   <= '0;
         r_rep_cnt    <= '0;
         r_level      <= 1'b0;
         r_press      <= 1'b0;
         r_release    <= 1'b0;
         r_hold_pulse <= 1'b0;
         r_hold_level <= 1'b0;
      end else begin
         r_sync1      <= i_btn_raw;
         r_sync2      <= r_sync1;
         r_state      <= w_state_nxt;
         r_ret_state  <= w_ret_nxt;
         r_db_cnt     <= w_db_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_rep_cnt    <= w_rep_nxt;
         r_level      <= w_level_nxt;
         r_press      <= w_press_nxt;
         r_release    <= w_release_nxt;
         r_hold_pulse <= w_hold_pulse_nxt;
         r_hold_level <= w_hold_level_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_ret_nxt        = r_ret_state;
      w_db_nxt         = r_db_cnt;
      w_hold_nxt       = r_hold_cnt;
      w_rep_nxt        = r_rep_cnt;
      w_level_nxt      = r_level;
      w_press_nxt      = 1'b0;
      w_release_nxt    = 1'b0;
      w_hold_pulse_nxt = 1'b0;
      w_hold_level_nxt = r_hold_level;

      case (r_state)
         IDLE, PRESS_DB: begin
            if (!r_sync2) begin
               w_state_nxt = IDLE;
               w_db_nxt    = '0;
            end else if (w_db_inc == DB_MAX) begin
               // Accepted press; with DEBOUNCE_CYCLES=1 this is taken
               // straight from IDLE so the latency stays fixed.
               w_state_nxt = PRESSED;
               w_ret_nxt   = PRESSED;
               w_db_nxt    = '0;
               w_level_nxt = 1'b1;
               w_press_nxt = 1'b1;
               w_hold_nxt  = HOLD_W'(1);
               w_rep_nxt   = '0;
               if (HOLD_MAX == HOLD_W'(1)) begin
                  w_state_nxt      = HELD;
                  w_ret_nxt        = HELD;
                  w_hold_pulse_nxt = 1'b1;
                  w_hold_level_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = PRESS_DB;
               w_db_nxt    = w_db_inc;
            end
         end

         PRESSED, HELD, REL_DB: begin
            // The hold timer keeps running through a release bounce, and
            // auto-repeat keeps its cadence as long as the long press is
            // still logically active (hold_level high).
            w_hold_nxt = w_hold_inc;
            if (w_hold_hit) begin
               w_ret_nxt        = HELD;
               w_hold_pulse_nxt = 1'b1;
               w_hold_level_nxt = 1'b1;
               w_rep_nxt        = '0;
            end else if (REPEAT_EN && r_hold_level) begin
               if (w_rep_inc == REP_MAX) begin
                  w_hold_pulse_nxt = 1'b1;
                  w_rep_nxt        = '0;
               end else begin
                  w_rep_nxt = w_rep_inc;
               end
            end

            if (r_sync2) begin
               // PRESSED/HELD stay put; REL_DB bounces back.
               w_state_nxt = w_ret_nxt;
               w_db_nxt    = '0;
            end else if (w_db_inc == DB_MAX) begin
               w_state_nxt      = IDLE;
               w_ret_nxt        = IDLE;
               w_db_nxt         = '0;
               w_hold_nxt       = '0;
               w_rep_nxt        = '0;
               w_level_nxt      = 1'b0;
               w_release_nxt    = 1'b1;
               w_hold_level_nxt = 1'b0;
            end else begin
               w_state_nxt = REL_DB;
               w_db_nxt    = w_db_inc;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_ret_nxt   = IDLE;
            w_db_nxt    = '0;
         end
      endcase
   end

   assign o_level      = r_level;
   assign o_press      = r_press;
   assign o_release    = r_release;
   assign o_hold_pulse = r_hold_pulse;
   assign o_hold_level = r_hold_level;
   assign o_state      = r_state;

endmodule : button_channel

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// N_CH independent button channels, each synchronized, debounced and timed
// for long-press / auto-repeat.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   btn_raw       raw button levels, 1 = pressed
//   btn_level     debounced level per channel
//   press_pulse   one-cycle pulse on debounced rise
//   release_pulse one-cycle pulse on debounced fall
//   hold_pulse    one-cycle long-press and repeat pulse
//   hold_level    high from the first hold_pulse until debounced release
//   dbg_state     per-channel FSM state, channel g at [g*STATE_W +: STATE_W]
// -----------------------------------------------------------------------------
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned N_CH            = DEF_N_CH,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_TIME       = DEF_HOLD_TIME,
   parameter bit          REPEAT_EN       = DEF_REPEAT_EN,
   parameter int unsigned REPEAT_TIME     = DEF_REPEAT_TIME
) (
   input  logic                      clk_in,
   input  logic                      rst_n,
   input  logic [N_CH-1:0]           btn_raw,
   output logic [N_CH-1:0]           btn_level,
   output logic [N_CH-1:0]           press_pulse,
   output logic [N_CH-1:0]           release_pulse,
   output logic [N_CH-1:0]           hold_pulse,
   output logic [N_CH-1:0]           hold_level,
   output logic [N_CH*STATE_W-1:0]   dbg_state
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_TIME       (HOLD_TIME),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_TIME     (REPEAT_TIME)
      ) u_ch (
         .i_clk        (clk_in),
         .i_rst_n      (rst_n),
         .i_btn_raw    (btn_raw[g]),
         .o_level      (btn_level[g]),
         .o_press      (press_pulse[g]),
         .o_release    (release_pulse[g]),
         .o_hold_pulse (hold_pulse[g]),
         .o_hold_level (hold_level[g]),
         .o_state      (dbg_state[g*STATE_W +: STATE_W])
      );
   end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Two conditioners on the same raw inputs: u_dut0 without auto-repeat,
// u_dut1 with auto-repeat. Timing: DEBOUNCE_CYCLES=4, HOLD_TIME=10,
// REPEAT_TIME=5.
// -----------------------------------------------------------------------------
module tb_button_conditioner;
   import button_pkg::*;

   localparam int NC = 4;
   localparam int DB = 4;
   localparam int HT = 10;
   localparam int RT = 5;

   logic              clk_in = 1'b0;
   logic              rst_n  = 1'b0;
   logic [NC-1:0]     btn_raw = '0;
   logic [NC-1:0]     lvl0, prs0, rel0, hp0, hl0;
   logic [NC-1:0]     lvl1, prs1, rel1, hp1, hl1;
   logic [NC*3-1:0]   dbg0, dbg1;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];

   // reference model state, [dut][channel]
   logic m_s1[NC];
   logic m_s2[NC];
   logic m_lvl[2][NC];
   logic m_held[2][NC];
   int   m_run[2][NC];
   int   m_age[2][NC];
   int   m_rep[2][NC];

   always #5 clk_in = ~clk_in;

   button_conditioner #(
      .N_CH(NC), .DEBOUNCE_CYCLES(DB), .HOLD_TIME(HT), .REPEAT_EN(1'b0), .REPEAT_TIME(RT)
   ) u_dut0 (
      .clk_in(clk_in), .rst_n(rst_n), .btn_raw(btn_raw),
      .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0),
      .hold_pulse(hp0), .hold_level(hl0), .dbg_state(dbg0)
   );

   button_conditioner #(
      .N_CH(NC), .DEBOUNCE_CYCLES(DB), .HOLD_TIME(HT), .REPEAT_EN(1'b1), .REPEAT_TIME(RT)
   ) u_dut1 (
      .clk_in(clk_in), .rst_n(rst_n), .btn_raw(btn_raw),
      .btn_level(lvl1), .press_pulse(prs1), .release_pulse(rel1),
      .hold_pulse(hp1), .hold_level(hl1), .dbg_state(dbg1)
   );

   task automatic apply_reset();
      @(negedge clk_in);
      rst_n   = 1'b0;
      btn_raw = '0;
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      @(negedge clk_in);
      btn_raw = '1;
      rst_n   = 1'b0;
      #1;
      total++;
      if ({lvl0, prs0, rel0, hp0, hl0} !== '0) begin
         bad++;
         $display("FAIL reset_out0 got=%h exp=0", {lvl0, prs0, rel0, hp0, hl0});
      end
      total++;
      if ({lvl1, prs1, rel1, hp1, hl1} !== '0) begin
         bad++;
         $display("FAIL reset_out1 got=%h exp=0", {lvl1, prs1, rel1, hp1, hl1});
      end
      repeat (5) @(negedge clk_in);
      total++;
      if ({dbg0, dbg1} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h exp=0", {dbg0, dbg1});
      end
      btn_raw = '0;
      rst_n   = 1'b1;
      repeat (10) @(negedge clk_in);
      total++;
      if ({lvl0, prs0, rel0, hp0, hl0, lvl1, prs1, rel1, hp1, hl1} !== '0) begin
         bad++;
         $display("FAIL reset_idle got=%h exp=0", {lvl0, prs0, rel0, hp0, hl0, lvl1, prs1, rel1, hp1, hl1});
      end
   endtask

   task automatic test_clean_press();
      apply_reset();
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk_in);
         total++;
         if (prs0 !== ((k == DB + 2) ? 4'b0001 : 4'b0000)) begin
            bad++;
            $display("FAIL press_ch0 k=%0d got=%b exp=%b", k, prs0, (k == DB + 2) ? 4'b0001 : 4'b0000);
         end
         total++;
         if (lvl0[0] !== (k >= DB + 2)) begin
            bad++;
            $display("FAIL level_ch0 k=%0d got=%b exp=%b", k, lvl0[0], (k >= DB + 2));
         end
      end
      total++;
      if (dbg0[2:0] !== PRESSED) begin
         bad++;
         $display("FAIL state_ch0 got=%0d exp=%0d", dbg0[2:0], PRESSED);
      end
      btn_raw[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         total++;
         if ((rel1[0] !== (k == DB + 2)) || (prs1[0] !== 1'b0)) begin
            bad++;
            $display("FAIL release_ch0 k=%0d got rel=%b prs=%b exp rel=%b prs=0", k, rel1[0], prs1[0], (k == DB + 2));
         end
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      btn_raw[1] = 1'b1;
      repeat (DB - 1) @(negedge clk_in);
      btn_raw[1] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_in);
         total++;
         if ({lvl0, prs0, rel0, hp0, hl0, lvl1, prs1, rel1, hp1, hl1} !== '0) begin
            bad++;
            $display("FAIL glitch k=%0d got=%h exp=0", k, {lvl0, prs0, rel0, hp0, hl0, lvl1, prs1, rel1, hp1, hl1});
         end
      end
   endtask

   task automatic test_hold();
      int press_k;
      press_k = DB + 2;
      apply_reset();
      exp_q.delete();
      exp_q.push_back(16'(press_k + HT - 1));
      exp_q.push_back(16'(press_k + HT - 1 + RT));
      exp_q.push_back(16'(press_k + HT - 1 + 2 * RT));
      btn_raw[2] = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk_in);
         total++;
         if (hp0[2] !== (k == press_k + HT - 1)) begin
            bad++;
            $display("FAIL hold_norep k=%0d got=%b exp=%b", k, hp0[2], (k == press_k + HT - 1));
         end
         total++;
         if (hl0[2] !== ((k >= press_k + HT - 1) && (k < 20 + DB + 2))) begin
            bad++;
            $display("FAIL hold_level k=%0d got=%b exp=%b", k, hl0[2], ((k >= press_k + HT - 1) && (k < 20 + DB + 2)));
         end
         total++;
         if ({rel0[2], rel1[2]} !== ((k == 20 + DB + 2) ? 2'b11 : 2'b00)) begin
            bad++;
            $display("FAIL hold_release k=%0d got=%b exp=%b", k, {rel0[2], rel1[2]}, (k == 20 + DB + 2) ? 2'b11 : 2'b00);
         end
         if (hp1[2] === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL repeat_pulse k=%0d got=extra pulse exp=none", k);
            end else begin
               if (exp_q[0] !== 16'(k)) begin
                  bad++;
                  $display("FAIL repeat_pulse got=%0d exp=%0d", k, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         if (k == 20) btn_raw[2] = 1'b0;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL repeat_missing got=%0d left exp=0 left", exp_q.size());
      end
   endtask

   task automatic test_all_four();
      apply_reset();
      btn_raw = 4'hF;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         total++;
         if ({prs0, prs1} !== ((k == DB + 2) ? 8'hFF : 8'h00)) begin
            bad++;
            $display("FAIL press_all k=%0d got=%h exp=%h", k, {prs0, prs1}, (k == DB + 2) ? 8'hFF : 8'h00);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      apply_reset();
      btn_raw = 4'hF;
      // press at k=6 loads the hold count with 1, so k=12 is count 7
      repeat (DB + 2 + 6) @(negedge clk_in);
      total++;
      if ({lvl0, hp0, hl0} !== {4'hF, 4'h0, 4'h0}) begin
         bad++;
         $display("FAIL pre_reset got=%h exp=%h", {lvl0, hp0, hl0}, {4'hF, 4'h0, 4'h0});
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({lvl0, prs0, rel0, hp0, hl0, lvl1, prs1, rel1, hp1, hl1, dbg0, dbg1} !== '0) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0", {lvl0, prs0, rel0, hp0, hl0, lvl1, prs1, rel1, hp1, hl1});
      end
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         total++;
         if ({prs1, lvl1} !== {((k == DB + 2) ? 4'hF : 4'h0), ((k >= DB + 2) ? 4'hF : 4'h0)}) begin
            bad++;
            $display("FAIL repress k=%0d got prs=%h lvl=%h exp prs=%h lvl=%h", k, prs1, lvl1,
                     (k == DB + 2) ? 4'hF : 4'h0, (k >= DB + 2) ? 4'hF : 4'h0);
         end
      end
   endtask

   // Reference behaviour of one channel for one clock edge, given the
   // synchronized sample seen at that edge.
   task automatic model_step(input int d, input int c, input logic s,
                             output logic lv, output logic pr, output logic rl,
                             output logic hp, output logic hl);
      logic hit;
      logic held_prev;
      hit = 1'b0; pr = 1'b0; rl = 1'b0; hp = 1'b0;
      held_prev = m_held[d][c];
      if (m_lvl[d][c]) begin
         if (m_age[d][c] < HT) begin
            m_age[d][c]++;
            hit = (m_age[d][c] == HT);
         end
         if (hit) begin
            hp = 1'b1; m_held[d][c] = 1'b1; m_rep[d][c] = 0;
         end else if (held_prev && d == 1) begin
            m_rep[d][c]++;
            if (m_rep[d][c] == RT) begin
               hp = 1'b1; m_rep[d][c] = 0;
            end
         end
      end
      if (s != m_lvl[d][c]) m_run[d][c]++;
      else                  m_run[d][c] = 0;
      if (m_run[d][c] == DB) begin
         m_run[d][c] = 0;
         if (!m_lvl[d][c]) begin
            m_lvl[d][c] = 1'b1; pr = 1'b1; m_age[d][c] = 1;
            if (HT == 1) begin
               hp = 1'b1; m_held[d][c] = 1'b1; m_rep[d][c] = 0;
            end
         end else begin
            m_lvl[d][c] = 1'b0; rl = 1'b1; m_held[d][c] = 1'b0;
            m_age[d][c] = 0; m_rep[d][c] = 0;
         end
      end
      lv = m_lvl[d][c];
      hl = m_held[d][c];
   endtask

   task automatic test_random();
      int rem[NC];
      logic [NC-1:0] e_lvl[2], e_prs[2], e_rel[2], e_hp[2], e_hl[2];
      logic s;
      apply_reset();
      for (int c = 0; c < NC; c++) begin
         rem[c] = 0; m_s1[c] = 1'b0; m_s2[c] = 1'b0;
         for (int d = 0; d < 2; d++) begin
            m_lvl[d][c] = 1'b0; m_held[d][c] = 1'b0;
            m_run[d][c] = 0; m_age[d][c] = 0; m_rep[d][c] = 0;
         end
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int c = 0; c < NC; c++) begin
            if (rem[c] == 0) begin
               btn_raw[c] = 1'($urandom_range(0, 1));
               rem[c] = (cyc[3]) ? $urandom_range(1, 6) : $urandom_range(1, 24);
            end
            rem[c]--;
         end
         @(posedge clk_in);
         for (int c = 0; c < NC; c++) begin
            s = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_raw[c];
            for (int d = 0; d < 2; d++)
               model_step(d, c, s, e_lvl[d][c], e_prs[d][c], e_rel[d][c], e_hp[d][c], e_hl[d][c]);
         end
         @(negedge clk_in);
         for (int d = 0; d < 2; d++) begin
            total++;
            if (((d == 0) ? lvl0 : lvl1) !== e_lvl[d]) begin
               bad++;
               $display("FAIL rnd_level dut%0d cyc=%0d got=%b exp=%b", d, cyc, (d == 0) ? lvl0 : lvl1, e_lvl[d]);
            end
            total++;
            if (((d == 0) ? prs0 : prs1) !== e_prs[d]) begin
               bad++;
               $display("FAIL rnd_press dut%0d cyc=%0d got=%b exp=%b", d, cyc, (d == 0) ? prs0 : prs1, e_prs[d]);
            end
            total++;
            if (((d == 0) ? rel0 : rel1) !== e_rel[d]) begin
               bad++;
               $display("FAIL rnd_release dut%0d cyc=%0d got=%b exp=%b", d, cyc, (d == 0) ? rel0 : rel1, e_rel[d]);
            end
            total++;
            if (((d == 0) ? hp0 : hp1) !== e_hp[d]) begin
               bad++;
               $display("FAIL rnd_hold_pulse dut%0d cyc=%0d got=%b exp=%b", d, cyc, (d == 0) ? hp0 : hp1, e_hp[d]);
            end
            total++;
            if (((d == 0) ? hl0 : hl1) !== e_hl[d]) begin
               bad++;
               $display("FAIL rnd_hold_level dut%0d cyc=%0d got=%b exp=%b", d, cyc, (d == 0) ? hl0 : hl1, e_hl[d]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_hold();
      test_all_four();
      test_reset_mid_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_button_conditioner
